// File: rtl/fetch_sequencer.sv
// Run-control FSM for the fetch PC unit: Init/Halt/Branch are combinational from state+decode, Ack/Timeout/counters registered.
// Latency: decode requests act on the fetch unit the same cycle; no backpressure, Start=1 aborts any run.
module fetch_sequencer #(
  parameter int unsigned STALL_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES   = 16'd60000
) (
  input  logic        CLK,
  input  logic        Init_n,
  input  logic        Start,
  input  logic [7:0]  PC,
  input  logic        HaltInstr,
  input  logic        StallReq,
  input  logic        BrReq,
  input  logic [7:0]  BrTarget,
  output logic        Init,
  output logic        Halt,
  output logic        Branch,
  output logic [7:0]  Target,
  output logic        Ack,
  output logic        Timeout,
  output logic [15:0] CycleCount,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_STALL,
    S_DONE
  } state_t;

  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);

  state_t     state;
  logic [3:0] stall_cnt;
  logic       wd_trip;
  logic       stall_cycle;
  logic       pc_unused;

  // PC is observed by the bench only; it never steers control
  assign pc_unused   = ^PC;
  assign Target      = BrTarget;
  assign wd_trip     = (CycleCount == (MAX_CYCLES - 16'd1));
  assign stall_cycle = StallReq && !HaltInstr;

  always_comb begin
    Init   = 1'b0;
    Halt   = 1'b1;
    Branch = 1'b0;
    case (state)
      S_INIT: begin
        Init = 1'b1;
        Halt = 1'b0;
      end
      S_RUN: begin
        if (HaltInstr || StallReq) begin
          Halt = 1'b1;
        end else begin
          Halt   = 1'b0;
          Branch = BrReq;
        end
      end
      default: Halt = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge Init_n) begin
    if (!Init_n) begin
      state      <= S_IDLE;
      stall_cnt  <= 4'd0;
      CycleCount <= 16'd0;
      InstrCount <= 16'd0;
      Ack        <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) state <= S_INIT;
        end
        S_INIT: begin
          CycleCount <= 16'd0;
          InstrCount <= 16'd0;
          Ack        <= 1'b0;
          Timeout    <= 1'b0;
          stall_cnt  <= 4'd0;
          if (!Start) state <= S_RUN;
        end
        S_RUN: begin
          if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
          if (!stall_cycle && InstrCount != 16'hFFFF) InstrCount <= InstrCount + 16'd1;
          if (Start) begin
            state <= S_INIT;
          end else if (HaltInstr) begin
            state   <= S_DONE;
            Ack     <= 1'b1;
            Timeout <= 1'b0;
          end else if (wd_trip) begin
            state   <= S_DONE;
            Ack     <= 1'b1;
            Timeout <= 1'b1;
          end else if (StallReq && STALL_CYCLES > 1) begin
            state     <= S_STALL;
            stall_cnt <= STALL_LOAD;
          end
        end
        S_STALL: begin
          if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
          if (Start) begin
            state <= S_INIT;
          end else if (wd_trip) begin
            state   <= S_DONE;
            Ack     <= 1'b1;
            Timeout <= 1'b1;
          end else if (stall_cnt <= 4'd1) begin
            // the raising RUN cycle already held once, so leave when the count runs out
            state     <= S_RUN;
            stall_cnt <= 4'd0;
          end else begin
            stall_cnt <= stall_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (Start) state <= S_INIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (STALL_CYCLES 2 and 1, MAX_CYCLES 20) each driving a small PC register model.
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Init_n = 1'b0;
  logic        Start = 1'b0;
  logic        HaltInstr = 1'b0;
  logic        StallReq = 1'b0;
  logic        BrReq = 1'b0;
  logic [7:0]  BrTarget = 8'h00;

  logic        a_Init, a_Halt, a_Branch, a_Ack, a_Timeout;
  logic [7:0]  a_Target, pc_a;
  logic [15:0] a_CycleCount, a_InstrCount;
  logic        b_Init, b_Halt, b_Branch, b_Ack, b_Timeout;
  logic [7:0]  b_Target, pc_b;
  logic [15:0] b_CycleCount, b_InstrCount;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 CLK = ~CLK;

  fetch_sequencer #(.STALL_CYCLES(2), .MAX_CYCLES(16'd20)) u_a (
    .CLK(CLK), .Init_n(Init_n), .Start(Start), .PC(pc_a),
    .HaltInstr(HaltInstr), .StallReq(StallReq), .BrReq(BrReq), .BrTarget(BrTarget),
    .Init(a_Init), .Halt(a_Halt), .Branch(a_Branch), .Target(a_Target),
    .Ack(a_Ack), .Timeout(a_Timeout), .CycleCount(a_CycleCount), .InstrCount(a_InstrCount)
  );

  fetch_sequencer #(.STALL_CYCLES(1), .MAX_CYCLES(16'd20)) u_b (
    .CLK(CLK), .Init_n(Init_n), .Start(Start), .PC(pc_b),
    .HaltInstr(HaltInstr), .StallReq(StallReq), .BrReq(BrReq), .BrTarget(BrTarget),
    .Init(b_Init), .Halt(b_Halt), .Branch(b_Branch), .Target(b_Target),
    .Ack(b_Ack), .Timeout(b_Timeout), .CycleCount(b_CycleCount), .InstrCount(b_InstrCount)
  );

  // fetch-unit PC registers
  always @(posedge CLK or negedge Init_n) begin
    if (!Init_n)       pc_a <= 8'h00;
    else if (a_Init)   pc_a <= 8'h00;
    else if (a_Branch) pc_a <= a_Target;
    else if (!a_Halt)  pc_a <= pc_a + 8'd1;
  end

  always @(posedge CLK or negedge Init_n) begin
    if (!Init_n)       pc_b <= 8'h00;
    else if (b_Init)   pc_b <= 8'h00;
    else if (b_Branch) pc_b <= b_Target;
    else if (!b_Halt)  pc_b <= pc_b + 8'd1;
  end

  task automatic start_run();
    @(negedge CLK);
    Start = 1'b1;
    repeat (3) @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic test_reset();
    int init_cyc;
    int halt_seen;
    logic [7:0] e;
    Init_n = 1'b0;
    #12;
    total++; if (a_Halt !== 1'b1) $display("FAIL reset_halt: got %b want 1", a_Halt); else passed++;
    total++; if (a_Init !== 1'b0 || a_Branch !== 1'b0) $display("FAIL reset_init_branch: got %b%b want 00", a_Init, a_Branch); else passed++;
    total++; if (a_Ack !== 1'b0 || a_Timeout !== 1'b0) $display("FAIL reset_ack_to: got %b%b want 00", a_Ack, a_Timeout); else passed++;
    total++; if (a_CycleCount !== 16'd0 || a_InstrCount !== 16'd0) $display("FAIL reset_counts: got %0d/%0d want 0/0", a_CycleCount, a_InstrCount); else passed++;
    @(negedge CLK);
    Init_n = 1'b1;
    @(negedge CLK);
    Start = 1'b1;
    init_cyc = 0;
    halt_seen = 0;
    repeat (3) begin
      @(negedge CLK); #1;
      if (a_Init) init_cyc++;
    end
    Start = 1'b0;
    for (int i = 0; i < 4; i++) exp_a.push_back(8'(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      if (a_Init) init_cyc++;
      if (a_Halt || a_Ack) halt_seen++;
      e = exp_a.pop_front();
      total++; if (pc_a !== e) $display("FAIL reset_pc_seq: got %h want %h", pc_a, e); else passed++;
    end
    total++; if (init_cyc !== 3) $display("FAIL init_cycles: got %0d want 3", init_cyc); else passed++;
    total++; if (halt_seen !== 0) $display("FAIL run_halt_ack: got %0d cycles with Halt/Ack want 0", halt_seen); else passed++;
  endtask

  task automatic test_halt();
    logic [7:0] e;
    start_run();
    for (int i = 0; i <= 5; i++) exp_a.push_back(8'(i));
    for (int i = 0; i <= 5; i++) begin
      @(negedge CLK);
      HaltInstr = (i == 5);
      #1;
      e = exp_a.pop_front();
      total++; if (pc_a !== e) $display("FAIL halt_pc_seq: got %h want %h", pc_a, e); else passed++;
      if (i == 5) begin
        total++; if (a_Halt !== 1'b1) $display("FAIL halt_same_cycle: got %b want 1", a_Halt); else passed++;
      end
    end
    @(negedge CLK);
    HaltInstr = 1'b0;
    #1;
    total++; if (pc_a !== 8'd5) $display("FAIL halt_pc_frozen: got %h want 05", pc_a); else passed++;
    total++; if (a_Ack !== 1'b1 || a_Timeout !== 1'b0) $display("FAIL halt_ack_to: got %b%b want 10", a_Ack, a_Timeout); else passed++;
    total++; if (a_InstrCount !== 16'd6) $display("FAIL halt_instr: got %0d want 6", a_InstrCount); else passed++;
    total++; if (a_CycleCount !== 16'd6) $display("FAIL halt_cycles: got %0d want 6", a_CycleCount); else passed++;
  endtask

  task automatic test_stall();
    logic [7:0] ta[9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd4, 8'd5, 8'd6};
    logic [7:0] tb[9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd4, 8'd5, 8'd6, 8'd7};
    logic [7:0] e;
    start_run();
    for (int i = 0; i < 9; i++) begin
      exp_a.push_back(ta[i]);
      exp_b.push_back(tb[i]);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      StallReq = (i == 4);
      #1;
      e = exp_a.pop_front();
      total++; if (pc_a !== e) $display("FAIL stall2_pc_seq: cycle %0d got %h want %h", i, pc_a, e); else passed++;
      e = exp_b.pop_front();
      total++; if (pc_b !== e) $display("FAIL stall1_pc_seq: cycle %0d got %h want %h", i, pc_b, e); else passed++;
      if (i == 5) begin
        total++; if (a_Halt !== 1'b1 || b_Halt !== 1'b0) $display("FAIL stall_hold_len: got a=%b b=%b want a=1 b=0", a_Halt, b_Halt); else passed++;
      end
    end
    @(negedge CLK);
    StallReq = 1'b0;
    #1;
    total++; if (a_CycleCount !== 16'd9) $display("FAIL stall2_cycles: got %0d want 9", a_CycleCount); else passed++;
    total++; if (a_InstrCount !== 16'd7) $display("FAIL stall2_instr: got %0d want 7", a_InstrCount); else passed++;
    total++; if (b_InstrCount !== 16'd8) $display("FAIL stall1_instr: got %0d want 8", b_InstrCount); else passed++;
  endtask

  task automatic test_branch_priority();
    logic [7:0] e;
    start_run();
    for (int i = 0; i < 8; i++) exp_a.push_back(8'(i));
    repeat (3) exp_a.push_back(8'h40);
    for (int i = 0; i <= 10; i++) begin
      @(negedge CLK);
      BrReq     = (i == 7 || i == 8 || i == 10);
      StallReq  = (i == 8);
      HaltInstr = (i == 10);
      BrTarget  = (i == 7) ? 8'h40 : 8'h99;
      #1;
      e = exp_a.pop_front();
      total++; if (pc_a !== e) $display("FAIL branch_pc_seq: cycle %0d got %h want %h", i, pc_a, e); else passed++;
      if (i == 7) begin
        total++; if (a_Branch !== 1'b1 || a_Target !== 8'h40) $display("FAIL branch_taken: got %b/%h want 1/40", a_Branch, a_Target); else passed++;
      end
      if (i == 8) begin
        total++; if (a_Branch !== 1'b0 || a_Halt !== 1'b1) $display("FAIL br_vs_stall: got br=%b halt=%b want 0/1", a_Branch, a_Halt); else passed++;
        total++; if (a_Target !== 8'h99) $display("FAIL target_pass: got %h want 99", a_Target); else passed++;
      end
      if (i == 10) begin
        total++; if (a_Branch !== 1'b0 || a_Halt !== 1'b1) $display("FAIL br_vs_halt: got br=%b halt=%b want 0/1", a_Branch, a_Halt); else passed++;
      end
    end
    @(negedge CLK);
    BrReq = 1'b0; StallReq = 1'b0; HaltInstr = 1'b0;
    #1;
    total++; if (pc_a !== 8'h40) $display("FAIL br_halt_pc: got %h want 40", pc_a); else passed++;
    total++; if (a_Ack !== 1'b1 || a_Timeout !== 1'b0) $display("FAIL br_halt_ack: got %b%b want 10", a_Ack, a_Timeout); else passed++;
  endtask

  task automatic test_watchdog();
    int cyc;
    bit done;
    logic [7:0] e;
    start_run();
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      BrReq    = 1'b1;
      BrTarget = 8'h00;
      exp_a.push_back(8'h00);
      #1;
      e = exp_a.pop_front();
      total++; if (pc_a !== e) $display("FAIL wd_pc_loop: got %h want %h", pc_a, e); else passed++;
      if (a_Ack) done = 1'b1;
      else cyc++;
    end
    BrReq = 1'b0;
    total++; if (!done || cyc !== 20) $display("FAIL wd_run_cycles: got %0d (done=%b) want 20", cyc, done); else passed++;
    total++; if (a_Timeout !== 1'b1 || b_Timeout !== 1'b1) $display("FAIL wd_timeout: got a=%b b=%b want 1/1", a_Timeout, b_Timeout); else passed++;
    total++; if (a_CycleCount !== 16'd20) $display("FAIL wd_cycles: got %0d want 20", a_CycleCount); else passed++;
    total++; if (a_InstrCount !== 16'd20) $display("FAIL wd_instr: got %0d want 20", a_InstrCount); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    logic [7:0] e;
    start_run();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      StallReq = (i == 3);
    end
    @(negedge CLK);
    StallReq = 1'b0;
    #1;
    total++; if (a_Halt !== 1'b1 || a_CycleCount !== 16'd4) $display("FAIL in_stall: got halt=%b cyc=%0d want 1/4", a_Halt, a_CycleCount); else passed++;
    #2;
    Init_n = 1'b0;
    #1;
    total++; if (a_Halt !== 1'b1 || a_Init !== 1'b0 || a_Ack !== 1'b0) $display("FAIL async_rst_ctl: got halt=%b init=%b ack=%b want 1/0/0", a_Halt, a_Init, a_Ack); else passed++;
    total++; if (a_CycleCount !== 16'd0 || a_InstrCount !== 16'd0) $display("FAIL async_rst_counts: got %0d/%0d want 0/0", a_CycleCount, a_InstrCount); else passed++;
    @(negedge CLK);
    Init_n = 1'b1;
    start_run();
    for (int i = 0; i < 3; i++) exp_a.push_back(8'(i));
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      e = exp_a.pop_front();
      total++; if (pc_a !== e) $display("FAIL restart_pc_seq: got %h want %h", pc_a, e); else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no completion want summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_halt();
    test_stall();
    test_branch_priority();
    test_watchdog();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
